instr_stream_encoder: RTL and testbench
=======================================

Name: instr_stream_encoder

Overview:
- Encoder and loader for the single-cycle MIPS: the inverse of the opcode decode path.
- Accepts one symbolic instruction per handshake (kind plus register/immediate fields) and builds the 32-bit instruction word with the processor's opcode map.
- Writes the words into instruction memory at consecutive word addresses.
- Used by bring-up benches and the boot-load path to fill instruction memory before the core runs.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth is 2**ADDR_W.
- BASE_ADDR, 0, first word address written after a start pulse.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: clear stream state, address := BASE_ADDR.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- req_kind  in  4  instruction kind (enum below).
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_funct  in  6  R-type funct.
- req_imm  in  16  immediate or branch offset.
- req_target  in  26  jump target.
- req_last  in  1  marks the final instruction of the stream.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written since start.
- done  out  1  stream finished (level).
- error  out  1  sticky: illegal kind or overflow.
- checksum  out  32  see Optional Feature.

Behaviour:
- Kind enum and opcodes: 0 RTYPE 000000, 1 ADDI 000010, 2 SUBI 000011, 3 ANDI 000100, 4 ORI 000101, 5 SLTI 000111, 6 LW 001000, 7 LB 001001, 8 SW 010000, 9 SB 010001, 10 BEQ 100011, 11 BNE 100111, 12 J 111000, 13 MOVE 100000. Kinds 14 and 15 are illegal.
- R format: {op, rs, rt, rd, 5'b0, funct}.
- I format (kinds 1-11): {op, rs, rt, imm}.
- MOVE: {op, rs, rt, 16'b0}; rs is the source, rt the destination.
- J: {op, target}.
- Unused request fields are ignored.
- States:
  - IDLE: req_ready=0.
  - ACCEPT: req_ready=1.
  - WRITE: req_ready=0.
  - DONE: req_ready=0.
- Transitions:
  - reset → IDLE.
  - start → ACCEPT from any state; clears count, done, error, checksum; addr := BASE_ADDR.
  - ACCEPT with valid&ready on cycle N: legal kind and not full → register word/addr, go to WRITE; imem_we=1 on cycle N+1 only; ACCEPT again on N+2. After the write, addr+1 and count+1.
  - Illegal kind: no write, error:=1, stay in ACCEPT (request consumed).
  - Full (count==2**ADDR_W): request consumed, no write, error:=1, go to DONE.
  - Request with req_last: after its WRITE, go to DONE with done=1. If req_last is on an illegal request, go to DONE directly.
  - DONE holds until start or reset.
- Address arithmetic: addr increments modulo 2**ADDR_W; the wrap is never written because of the full check.
- start and valid in the same cycle: start wins; the request is not accepted.
- reset mid-WRITE: the strobe is dropped the same cycle.
- Reset values: req_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0, error=0, checksum=0.

Optional Feature:
- Macro: INSTR_ENC_CHECKSUM_EN.
- Defined: checksum is the running XOR of every written word. It updates in the cycle after imem_we and clears on start/reset.
- Undefined: checksum is tied to 0 and no register is built.

Decomposition:
- Package instr_enc_pkg: kind enum (4-bit), 6-bit opcode localparams, field bit positions (op 31:26, rs 25:21, rt 20:16, rd 15:11, funct 5:0).
  - The same opcode constants are shared with the control decode logic so the encode and decode maps cannot diverge.
- Sub-module instr_word_encoder: combinational; inputs are kind plus fields, outputs are word and illegal. The FSM, address counter and checksum stay in the top module.

Test Plan:
- ADDI rs=8 rt=9 imm=5 after start → one cycle later imem_we=1, addr=0, wdata=0x09090005; count=1.
- RTYPE rs=8 rt=9 rd=10 funct=0x20, then BEQ rs=1 rt=2 imm=0xFFFF with last → 0x01095020 @0, 0x8C22FFFF @1, done=1, req_ready=0.
- J target=0x10 → 0xE0000010. Then kind=14 → no imem_we, error=1, encoder still accepting; the next legal request writes at the next address.
- ADDR_W=2: five back-to-back ADDI requests → writes at 0..3, fifth sets error=1, no write, DONE, count=4.
- start asserted together with req_valid mid-stream → request not accepted, count=0, next write at BASE_ADDR. Reset during WRITE → imem_we=0 that cycle, all outputs at reset values.
- With INSTR_ENC_CHECKSUM_EN: words 0x09090005 then 0x01095020 → checksum=0x08005025. Without the macro, checksum stays 0.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared opcode map, field positions and request payload for the MIPS instruction encoder.
package instr_enc_pkg;

    typedef enum logic [3:0] {
        KIND_RTYPE = 4'd0,
        KIND_ADDI  = 4'd1,
        KIND_SUBI  = 4'd2,
        KIND_ANDI  = 4'd3,
        KIND_ORI   = 4'd4,
        KIND_SLTI  = 4'd5,
        KIND_LW    = 4'd6,
        KIND_LB    = 4'd7,
        KIND_SW    = 4'd8,
        KIND_SB    = 4'd9,
        KIND_BEQ   = 4'd10,
        KIND_BNE   = 4'd11,
        KIND_J     = 4'd12,
        KIND_MOVE  = 4'd13,
        KIND_ILL14 = 4'd14,
        KIND_ILL15 = 4'd15
    } kind_e;

    // Opcodes shared with the control decoder so both maps stay in lockstep.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_SUBI  = 6'b000011;
    localparam logic [5:0] OP_ANDI  = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b001001;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_SB    = 6'b010001;
    localparam logic [5:0] OP_BEQ   = 6'b100011;
    localparam logic [5:0] OP_BNE   = 6'b100111;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_MOVE  = 6'b100000;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned TGT_MSB   = 25;
    localparam int unsigned TGT_LSB   = 0;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } enc_state_e;

    // Opcode for a kind; illegal kinds map to zero and are flagged separately.
    function automatic logic [5:0] kind_opcode(input kind_e k);
        logic [5:0] op;
        op = OP_RTYPE;
        case (k)
            KIND_ADDI: op = OP_ADDI;
            KIND_SUBI: op = OP_SUBI;
            KIND_ANDI: op = OP_ANDI;
            KIND_ORI:  op = OP_ORI;
            KIND_SLTI: op = OP_SLTI;
            KIND_LW:   op = OP_LW;
            KIND_LB:   op = OP_LB;
            KIND_SW:   op = OP_SW;
            KIND_SB:   op = OP_SB;
            KIND_BEQ:  op = OP_BEQ;
            KIND_BNE:  op = OP_BNE;
            KIND_J:    op = OP_J;
            KIND_MOVE: op = OP_MOVE;
            default:   op = OP_RTYPE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Request handshake and instruction-memory write bus of the stream encoder.
interface instr_stream_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_kind;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [5:0]        req_funct;
    logic [15:0]       req_imm;
    logic [25:0]       req_target;
    logic              req_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output req_valid, req_kind, req_rs, req_rt, req_rd, req_funct,
               req_imm, req_target, req_last,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_kind, req_rs, req_rt, req_rd, req_funct,
               req_imm, req_target, req_last,
        output req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_word_encoder.sv
// Combinational symbolic-instruction to 32-bit MIPS word encoder.
module instr_word_encoder
    import instr_enc_pkg::*;
(
    input  instr_req_t  req,
    output logic [31:0] word,
    output logic        illegal
);

    // Place fields by instruction format; unused request fields never reach the word.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        word[OP_MSB:OP_LSB] = kind_opcode(req.kind);
        case (req.kind)
            KIND_RTYPE: begin
                word[RS_MSB:RS_LSB]       = req.rs;
                word[RT_MSB:RT_LSB]       = req.rt;
                word[RD_MSB:RD_LSB]       = req.rd;
                word[FUNCT_MSB:FUNCT_LSB] = req.funct;
            end
            KIND_ADDI, KIND_SUBI, KIND_ANDI, KIND_ORI, KIND_SLTI, KIND_LW,
            KIND_LB, KIND_SW, KIND_SB, KIND_BEQ, KIND_BNE: begin
                word[RS_MSB:RS_LSB]   = req.rs;
                word[RT_MSB:RT_LSB]   = req.rt;
                word[IMM_MSB:IMM_LSB] = req.imm;
            end
            KIND_MOVE: begin
                word[RS_MSB:RS_LSB] = req.rs;
                word[RT_MSB:RT_LSB] = req.rt;
            end
            KIND_J: begin
                word[TGT_MSB:TGT_LSB] = req.target;
            end
            default: begin
                word    = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder/loader: encodes one request per handshake and writes
// it to consecutive instruction-memory words.
// Optional macro INSTR_ENC_CHECKSUM_EN builds a running XOR of written words.
module instr_stream_encoder
    import instr_enc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    instr_stream_encoder_if.slave bus,
    output logic [ADDR_W:0]      count,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          checksum
);

    localparam int unsigned      CNT_W      = ADDR_W + 1;
    localparam logic [ADDR_W:0]  FULL_COUNT = CNT_W'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    enc_state_e        state_q, state_d;
    instr_req_t        req;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              load_c, err_set_c, wr_done_c, full_c;
    logic              ready_q, we_q, done_q, error_q, last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;

    assign req = '{kind:   kind_e'(bus.req_kind),
                   rs:     bus.req_rs,
                   rt:     bus.req_rt,
                   rd:     bus.req_rd,
                   funct:  bus.req_funct,
                   imm:    bus.req_imm,
                   target: bus.req_target};

    instr_word_encoder u_enc (
        .req     (req),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign full_c = (count_q == FULL_COUNT);

    // Next state and per-cycle actions; start overrides everything including a pending request.
    always_comb begin
        state_d   = state_q;
        load_c    = 1'b0;
        err_set_c = 1'b0;
        wr_done_c = 1'b0;
        if (start) begin
            state_d = ST_ACCEPT;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (bus.req_valid) begin
                        if (full_c) begin
                            err_set_c = 1'b1;
                            state_d   = ST_DONE;
                        end else if (enc_illegal) begin
                            err_set_c = 1'b1;
                            if (bus.req_last) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            load_c  = 1'b1;
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    wr_done_c = 1'b1;
                    state_d   = last_q ? ST_DONE : ST_ACCEPT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered handshake, strobe and done flags follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= (state_d == ST_ACCEPT);
            we_q    <= (state_d == ST_WRITE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Write word/address, word counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= BASE;
            wdata_q <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            error_q <= 1'b0;
        end else if (start) begin
            addr_q  <= BASE;
            last_q  <= 1'b0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (load_c) begin
                wdata_q <= enc_word;
                last_q  <= bus.req_last;
            end
            if (wr_done_c) begin
                addr_q  <= addr_q + ADDR_W'(1);
                count_q <= count_q + CNT_W'(1);
            end
            if (err_set_c) begin
                error_q <= 1'b1;
            end
        end
    end

`ifdef INSTR_ENC_CHECKSUM_EN
    logic [31:0] csum_q;

    // Running XOR of every word, folded in as its write completes.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            csum_q <= '0;
        end else if (wr_done_c) begin
            csum_q <= csum_q ^ wdata_q;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    // The strobe is masked by reset so a write in flight is dropped immediately.
    assign bus.req_ready  = ready_q;
    assign bus.imem_we    = we_q & ~reset;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign count          = count_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench for instr_stream_encoder (default and 2-bit-address instances).
module tb_instr_stream_encoder;

    localparam int unsigned AW    = 8;
    localparam int unsigned AW2   = 2;
    localparam int          DEPTH = 256;

    // Opcode per legal kind, straight from the processor opcode map.
    localparam logic [5:0] OP_TBL [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h07, 6'h08,
                                            6'h09, 6'h10, 6'h11, 6'h23, 6'h27, 6'h38, 6'h20};

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
        logic [31:0] exp_word;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [AW:0]  count;
    logic [AW2:0] count2;
    logic done, error, done2, error2;
    logic [31:0] checksum, checksum2;

    int checks = 0;
    int errors = 0;

    int          m_addr;
    int          m_count;
    bit          m_err;
    bit          m_done;
    logic [31:0] m_csum;

    vec_t vecs [14];

    always #5 clk = ~clk;

    instr_stream_encoder_if #(.ADDR_W(AW))  bus  ();
    instr_stream_encoder_if #(.ADDR_W(AW2)) bus2 ();

    assign bus2.req_valid  = bus.req_valid;
    assign bus2.req_kind   = bus.req_kind;
    assign bus2.req_rs     = bus.req_rs;
    assign bus2.req_rt     = bus.req_rt;
    assign bus2.req_rd     = bus.req_rd;
    assign bus2.req_funct  = bus.req_funct;
    assign bus2.req_imm    = bus.req_imm;
    assign bus2.req_target = bus.req_target;
    assign bus2.req_last   = bus.req_last;

    instr_stream_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .count(count), .done(done), .error(error), .checksum(checksum)
    );

    instr_stream_encoder #(.ADDR_W(AW2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .start(start), .bus(bus2),
        .count(count2), .done(done2), .error(error2), .checksum(checksum2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoding built from the format rules with plain arithmetic.
    function automatic logic [31:0] model_encode(input vec_t v);
        logic [31:0] op;
        if (v.kind > 4'd13) return 32'd0;
        op = 32'(OP_TBL[v.kind]) << 26;
        if (v.kind == 4'd0)
            return op | (32'(v.rs) << 21) | (32'(v.rt) << 16) | (32'(v.rd) << 11) | 32'(v.funct);
        if (v.kind == 4'd12) return op | 32'(v.target);
        if (v.kind == 4'd13) return op | (32'(v.rs) << 21) | (32'(v.rt) << 16);
        return op | (32'(v.rs) << 21) | (32'(v.rt) << 16) | 32'(v.imm);
    endfunction

    function automatic logic [31:0] exp_checksum();
`ifdef INSTR_ENC_CHECKSUM_EN
        return m_csum;
`else
        return 32'd0;
`endif
    endfunction

    function automatic vec_t mk(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                                input logic [25:0] tgt, input logic last, input logic [31:0] w);
        vec_t v;
        v.kind = k; v.rs = rs; v.rt = rt; v.rd = rd; v.funct = fn;
        v.imm = imm; v.target = tgt; v.last = last; v.exp_word = w;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.req_kind   = v.kind;
        bus.req_rs     = v.rs;
        bus.req_rt     = v.rt;
        bus.req_rd     = v.rd;
        bus.req_funct  = v.funct;
        bus.req_imm    = v.imm;
        bus.req_target = v.target;
        bus.req_last   = v.last;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_addr = 0; m_count = 0; m_err = 0; m_done = 0; m_csum = '0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.req_ready) check({name, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
    endtask

    // One request through the handshake, checked against the model two cycles deep.
    task automatic send(input vec_t v, input string name);
        bit legal;
        bit full;
        wait_ready(name);
        drive(v);
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        legal = (v.kind < 4'd14);
        full  = (m_count == DEPTH);
        if (full) begin
            m_err = 1; m_done = 1;
            check({name, "_we"}, 32'(bus.imem_we), 32'd0);
        end else if (!legal) begin
            m_err = 1;
            if (v.last) m_done = 1;
            check({name, "_we"}, 32'(bus.imem_we), 32'd0);
        end else begin
            check({name, "_we"}, 32'(bus.imem_we), 32'd1);
            check({name, "_addr"}, 32'(bus.imem_addr), 32'(m_addr));
            check({name, "_wdata"}, bus.imem_wdata, v.exp_word);
            m_addr  = (m_addr + 1) % DEPTH;
            m_count = m_count + 1;
            m_csum  = m_csum ^ v.exp_word;
            if (v.last) m_done = 1;
        end
        tick();
        check({name, "_count"}, 32'(count), 32'(m_count));
        check({name, "_error"}, 32'(error), 32'(m_err));
        check({name, "_done"}, 32'(done), 32'(m_done));
        check({name, "_ready"}, 32'(bus.req_ready), 32'(!m_done));
        check({name, "_csum"}, checksum, exp_checksum());
    endtask

    task automatic check_reset(input string name);
        check({name, "_ready"}, 32'(bus.req_ready), 32'd0);
        check({name, "_we"}, 32'(bus.imem_we), 32'd0);
        check({name, "_addr"}, 32'(bus.imem_addr), 32'd0);
        check({name, "_wdata"}, bus.imem_wdata, 32'd0);
        check({name, "_count"}, 32'(count), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
        check({name, "_csum"}, checksum, 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [31:0] csum_two;
`ifdef INSTR_ENC_CHECKSUM_EN
        csum_two = 32'h08005025;
`else
        csum_two = 32'h0;
`endif
        vecs[0]  = mk(4'd1,  5'd8,  5'd9,  5'd0,  6'h00, 16'h0005, 26'h0,       1'b0, 32'h09090005);
        vecs[1]  = mk(4'd0,  5'd8,  5'd9,  5'd10, 6'h20, 16'h0000, 26'h0,       1'b0, 32'h01095020);
        vecs[2]  = mk(4'd10, 5'd1,  5'd2,  5'd0,  6'h00, 16'hFFFF, 26'h0,       1'b1, 32'h8C22FFFF);
        vecs[3]  = mk(4'd12, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h10,      1'b0, 32'hE0000010);
        vecs[4]  = mk(4'd14, 5'd1,  5'd1,  5'd1,  6'h01, 16'h0001, 26'h1,       1'b0, 32'h00000000);
        vecs[5]  = mk(4'd13, 5'd3,  5'd4,  5'd7,  6'h15, 16'hBEEF, 26'h3,       1'b0, 32'h80640000);
        vecs[6]  = mk(4'd8,  5'd29, 5'd31, 5'd0,  6'h00, 16'h0010, 26'h0,       1'b0, 32'h43BF0010);
        vecs[7]  = mk(4'd7,  5'd0,  5'd1,  5'd0,  6'h00, 16'h8000, 26'h0,       1'b0, 32'h24018000);
        vecs[8]  = mk(4'd5,  5'd31, 5'd0,  5'd0,  6'h00, 16'h1234, 26'h0,       1'b0, 32'h1FE01234);
        vecs[9]  = mk(4'd11, 5'd5,  5'd6,  5'd0,  6'h00, 16'h0003, 26'h0,       1'b0, 32'h9CA60003);
        vecs[10] = mk(4'd4,  5'd2,  5'd3,  5'd0,  6'h00, 16'hABCD, 26'h0,       1'b0, 32'h1443ABCD);
        vecs[11] = mk(4'd0,  5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h03FFF83F);
        vecs[12] = mk(4'd12, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'hE3FFFFFF);
        vecs[13] = mk(4'd15, 5'd2,  5'd2,  5'd2,  6'h02, 16'h0002, 26'h2,       1'b1, 32'h00000000);

        reset = 1'b1;
        start = 1'b0;
        bus.req_valid = 1'b0;
        drive(vecs[0]);
        tick();
        tick();
        check_reset("rst");
        reset = 1'b0;
        tick();
        check("idle_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b1;
        tick();
        check("idle_no_we", 32'(bus.imem_we), 32'd0);
        tick();
        check("idle_count", 32'(count), 32'd0);
        bus.req_valid = 1'b0;

        // Directed table: encodings, illegal kinds, last handling.
        do_start();
        for (int i = 0; i < 14; i++) begin
            if (m_done) do_start();
            send(vecs[i], $sformatf("vec%0d", i));
            if (i == 1) check("csum_two_words", checksum, csum_two);
            if (vecs[i].last) begin
                bus.req_valid = 1'b1;
                tick();
                check($sformatf("vec%0d_done_hold_we", i), 32'(bus.imem_we), 32'd0);
                check($sformatf("vec%0d_done_hold", i), 32'(done), 32'd1);
                bus.req_valid = 1'b0;
            end
        end

        // Overflow on the 4-word instance: five back-to-back ADDI requests.
        do_start();
        for (int i = 0; i < 5; i++) begin
            int n = 0;
            while (!bus2.req_ready && n < 20) begin
                tick();
                n++;
            end
            if (!bus2.req_ready) check("full_ready_timeout", 32'(bus2.req_ready), 32'd1);
            drive(vecs[0]);
            bus.req_valid = 1'b1;
            tick();
            bus.req_valid = 1'b0;
            check($sformatf("full_we%0d", i), 32'(bus2.imem_we), 32'(i < 4));
            if (i < 4) check($sformatf("full_addr%0d", i), 32'(bus2.imem_addr), 32'(i));
            tick();
            if (i < 4) check($sformatf("full_err_early%0d", i), 32'(error2), 32'd0);
        end
        check("full_count", 32'(count2), 32'd4);
        check("full_error", 32'(error2), 32'd1);
        check("full_done", 32'(done2), 32'd1);
        check("full_ready", 32'(bus2.req_ready), 32'd0);

        // start together with a valid request mid-stream.
        do_start();
        send(vecs[0], "ss_first");
        wait_ready("ss");
        drive(vecs[3]);
        bus.req_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.req_valid = 1'b0;
        m_addr = 0; m_count = 0; m_err = 0; m_done = 0; m_csum = '0;
        check("ss_we", 32'(bus.imem_we), 32'd0);
        check("ss_count", 32'(count), 32'd0);
        check("ss_ready", 32'(bus.req_ready), 32'd1);
        send(vecs[3], "ss_next");

        // Randomized stream against the reference model.
        do_start();
        for (int i = 0; i < 60; i++) begin
            v.kind   = ($urandom_range(0, 7) == 0) ? 4'(14 + $urandom_range(0, 1))
                                                   : 4'($urandom_range(0, 13));
            v.rs     = 5'($urandom);
            v.rt     = 5'($urandom);
            v.rd     = 5'($urandom);
            v.funct  = 6'($urandom);
            v.imm    = 16'($urandom);
            v.target = 26'($urandom);
            v.last   = (i == 59);
            v.exp_word = model_encode(v);
            send(v, $sformatf("rnd%0d", i));
        end

        // Reset arriving during the write cycle.
        do_start();
        wait_ready("rw");
        drive(vecs[0]);
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("rw_we", 32'(bus.imem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("rw_we_drop", 32'(bus.imem_we), 32'd0);
        tick();
        check_reset("rw");
        reset = 1'b0;
        tick();
        check("rw_idle_ready", 32'(bus.req_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
